// File: rtl/pspin_stdout_pkg.sv
// Shared constants for the PsPIN stdout path, visible to the FIFO and the
// control-register block so both sides agree on widths, offsets and patterns.
package pspin_stdout_pkg;

    localparam int unsigned STDOUT_DATA_WIDTH = 32;
    localparam int unsigned STDOUT_STAT_WIDTH = 32;

    // Host-visible register offset of the stdout FIFO pop port.
    localparam logic [31:0] STDOUT_FIFO_OFFSET = 32'h0000_1000;

    // Value returned to the host when it reads an empty stdout FIFO.
    localparam logic [STDOUT_DATA_WIDTH-1:0] STDOUT_INVALID_READ = '1;

    // Saturating increment for statistics counters.
    function automatic logic [STDOUT_STAT_WIDTH-1:0] sat_inc(
        input logic [STDOUT_STAT_WIDTH-1:0] v
    );
        return (&v) ? v : v + STDOUT_STAT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/pspin_stdout_fifo_if.sv
// Stream-in / FWFT-out signal bundle of the stdout FIFO.
// slave: the FIFO itself. master: the PsPIN writer plus control-register reader.
interface pspin_stdout_fifo_if
    import pspin_stdout_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = STDOUT_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] s_stdout_data;
    logic                  s_stdout_valid;
    logic                  s_stdout_ready;
    logic                  stdout_rd_en;
    logic [DATA_WIDTH-1:0] stdout_dout;
    logic                  stdout_data_valid;

    modport slave (
        input  s_stdout_data,
        input  s_stdout_valid,
        input  stdout_rd_en,
        output s_stdout_ready,
        output stdout_dout,
        output stdout_data_valid
    );

    modport master (
        output s_stdout_data,
        output s_stdout_valid,
        output stdout_rd_en,
        input  s_stdout_ready,
        input  stdout_dout,
        input  stdout_data_valid
    );
endinterface

// File: rtl/pspin_stdout_ram.sv
// Simple dual-port RAM: one write port, one registered read port (BRAM style).
// Read-during-write to the same address returns the old contents.
module pspin_stdout_ram
    import pspin_stdout_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = STDOUT_DATA_WIDTH,
    parameter int unsigned DEPTH      = 1024,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; rdata holds between reads.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pspin_stdout_fifo.sv
// Stdout word FIFO between the PsPIN stdout collector and the control-register
// block. Built without RAM bypass: a push into an empty FIFO appears on
// stdout_dout after two edges (RAM read into its output stage, then load into
// the FWFT register). The RAM read stage doubles as a prefetch slot so that
// consecutive pops never see a bubble. The RAM is addressed with the pointer
// LSBs and sized to DEPTH for power-of-two wrap; total occupancy across RAM,
// prefetch slot and output register is limited to DEPTH by fill_level.
module pspin_stdout_fifo
    import pspin_stdout_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = STDOUT_DATA_WIDTH,
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned DROP_WHEN_FULL = 0,
    parameter int unsigned LEVEL_WIDTH    = $clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    pspin_stdout_fifo_if.slave           bus,
    output logic [LEVEL_WIDTH-1:0]       fill_level,
    output logic [STDOUT_STAT_WIDTH-1:0] drop_count,
    input  logic                         clr_stats
);

    localparam int unsigned PW = $clog2(DEPTH) + 1;

    logic [PW-1:0]                wptr_q, wptr_d, rptr_q, rptr_d, mem_cnt;
    logic                         mid_valid_q, mid_valid_d;
    logic                         out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]        out_q, out_d, ram_rdata;
    logic [LEVEL_WIDTH-1:0]       level_q, level_d;
    logic [STDOUT_STAT_WIDTH-1:0] drop_q, drop_d;
    logic                         ready_en_q;
    logic                         full, ready, push, drop, pop, out_load, ram_rd;

    assign full  = (level_q == LEVEL_WIDTH'(DEPTH));
    assign ready = ready_en_q && ((DROP_WHEN_FULL != 0) || !full);
    assign push  = bus.s_stdout_valid && ready && !full;
    // Full is registered, so a word arriving on a pop cycle while full is dropped.
    assign drop  = bus.s_stdout_valid && ready && full;
    assign pop   = bus.stdout_rd_en && out_valid_q;

    // Output register refills from the prefetch slot when empty or being popped.
    assign out_load = mid_valid_q && (!out_valid_q || pop);
    assign mem_cnt  = wptr_q - rptr_q;
    // Issue a RAM read whenever the prefetch slot is free or draining this cycle.
    assign ram_rd   = (mem_cnt != '0) && (!mid_valid_q || out_load);

    pspin_stdout_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wptr_q[PW-2:0]),
        .wdata (bus.s_stdout_data),
        .re    (ram_rd),
        .raddr (rptr_q[PW-2:0]),
        .rdata (ram_rdata)
    );

    // Next-state for pointers, valid flags, output word, level and statistics.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        mid_valid_d = mid_valid_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        level_d     = level_q;
        drop_d      = drop_q;

        if (push) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (ram_rd) begin
            rptr_d = rptr_q + PW'(1);
        end

        if (ram_rd) begin
            mid_valid_d = 1'b1;
        end else if (out_load) begin
            mid_valid_d = 1'b0;
        end

        if (out_load) begin
            out_valid_d = 1'b1;
            out_d       = ram_rdata;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + LEVEL_WIDTH'(1);
            2'b01:   level_d = level_q - LEVEL_WIDTH'(1);
            default: level_d = level_q;
        endcase

        if (clr_stats) begin
            drop_d = '0;
        end else if (drop) begin
            drop_d = sat_inc(drop_q);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            mid_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            level_q     <= '0;
            drop_q      <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            mid_valid_q <= mid_valid_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            level_q     <= level_d;
            drop_q      <= drop_d;
            ready_en_q  <= 1'b1;
        end
    end

    assign bus.s_stdout_ready    = ready;
    assign bus.stdout_dout       = out_q;
    assign bus.stdout_data_valid = out_valid_q;
    assign fill_level            = level_q;
    assign drop_count            = drop_q;

endmodule

// File: tb/tb_pspin_stdout_fifo.sv
// Bench for pspin_stdout_fifo. Three instances share clock and reset:
//   0: DEPTH=16, backpressure   1: DEPTH=8, backpressure   2: DEPTH=8, drop-when-full
// Stored words are queued per instance; a negedge monitor checks every pop.
module tb_pspin_stdout_fifo;
    import pspin_stdout_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pspin_stdout_fifo_if #(.DATA_WIDTH(32)) if_a ();
    pspin_stdout_fifo_if #(.DATA_WIDTH(32)) if_b ();
    pspin_stdout_fifo_if #(.DATA_WIDTH(32)) if_c ();

    logic [4:0]  fl_a;
    logic [3:0]  fl_b, fl_c;
    logic [31:0] dc_a, dc_b, dc_c;

    logic [31:0] wdata  [3];
    logic        wvalid [3];
    logic        rd_en  [3];
    logic        clr    [3];
    logic [31:0] dout   [3];
    logic [31:0] lvl    [3];
    logic [31:0] drops  [3];
    logic        rdy    [3];
    logic        dv     [3];

    assign if_a.s_stdout_data = wdata[0];
    assign if_b.s_stdout_data = wdata[1];
    assign if_c.s_stdout_data = wdata[2];
    assign if_a.s_stdout_valid = wvalid[0];
    assign if_b.s_stdout_valid = wvalid[1];
    assign if_c.s_stdout_valid = wvalid[2];
    assign if_a.stdout_rd_en = rd_en[0];
    assign if_b.stdout_rd_en = rd_en[1];
    assign if_c.stdout_rd_en = rd_en[2];
    assign dout[0] = if_a.stdout_dout;
    assign dout[1] = if_b.stdout_dout;
    assign dout[2] = if_c.stdout_dout;
    assign dv[0]   = if_a.stdout_data_valid;
    assign dv[1]   = if_b.stdout_data_valid;
    assign dv[2]   = if_c.stdout_data_valid;
    assign rdy[0]  = if_a.s_stdout_ready;
    assign rdy[1]  = if_b.s_stdout_ready;
    assign rdy[2]  = if_c.s_stdout_ready;
    assign lvl[0]  = {27'd0, fl_a};
    assign lvl[1]  = {28'd0, fl_b};
    assign lvl[2]  = {28'd0, fl_c};
    assign drops[0] = dc_a;
    assign drops[1] = dc_b;
    assign drops[2] = dc_c;

    pspin_stdout_fifo #(.DATA_WIDTH(32), .DEPTH(16), .DROP_WHEN_FULL(0)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a), .fill_level(fl_a), .drop_count(dc_a),
        .clr_stats(clr[0])
    );
    pspin_stdout_fifo #(.DATA_WIDTH(32), .DEPTH(8), .DROP_WHEN_FULL(0)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b), .fill_level(fl_b), .drop_count(dc_b),
        .clr_stats(clr[1])
    );
    pspin_stdout_fifo #(.DATA_WIDTH(32), .DEPTH(8), .DROP_WHEN_FULL(1)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c), .fill_level(fl_c), .drop_count(dc_c),
        .clr_stats(clr[2])
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];
    logic [31:0] exp_q2 [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic int sb_size(input int i);
        case (i)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    task automatic sb_push(input int i, input logic [31:0] d);
        case (i)
            0:       exp_q0.push_back(d);
            1:       exp_q1.push_back(d);
            default: exp_q2.push_back(d);
        endcase
    endtask

    task automatic sb_pop(input int i, input logic [31:0] got);
        logic [31:0] e;
        if (sb_size(i) == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pop_%0d: got 0x%08h, expected no word", i, got);
        end else begin
            case (i)
                0:       e = exp_q0.pop_front();
                1:       e = exp_q1.pop_front();
                default: e = exp_q2.pop_front();
            endcase
            check($sformatf("pop_%0d", i), got, e);
        end
    endtask

    // Monitor: a pop happens at the next posedge whenever rd_en and data_valid are high.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (rd_en[i] && dv[i]) sb_pop(i, dout[i]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input logic [31:0] d, input bit store);
        int n;
        n = 0;
        wvalid[i] = 1'b1;
        wdata[i]  = d;
        while (!rdy[i] && n < 50) begin
            step();
            n++;
        end
        if (!rdy[i]) begin
            fail_now($sformatf("push_timeout_%0d", i));
        end else begin
            step();
            if (store) sb_push(i, d);
        end
        wvalid[i] = 1'b0;
    endtask

    task automatic wait_dv(input int i, input int max);
        int n;
        n = 0;
        while (!dv[i] && n < max) begin
            step();
            n++;
        end
        check($sformatf("dv_latency_%0d", i), {31'd0, dv[i]}, 32'd1);
    endtask

    task automatic drain(input int i, input string name);
        int n;
        n = 0;
        rd_en[i] = 1'b1;
        while (lvl[i] != 0 && n < 64) begin
            step();
            n++;
        end
        rd_en[i] = 1'b0;
        check({name, "_level"}, lvl[i], 32'd0);
        check({name, "_dv"}, {31'd0, dv[i]}, 32'd0);
        check({name, "_sb_empty"}, sb_size(i), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps;
        for (int i = 0; i < 3; i++) begin
            wdata[i]  = '0;
            wvalid[i] = 1'b0;
            rd_en[i]  = 1'b0;
            clr[i]    = 1'b0;
        end

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        check("rst_dv", {31'd0, dv[0]}, 32'd0);
        check("rst_level", lvl[0], 32'd0);
        check("rst_drop", drops[2], 32'd0);
        check("rst_dout", dout[0], 32'd0);
        check("rst_ready_a", {31'd0, rdy[0]}, 32'd0);
        check("rst_ready_c", {31'd0, rdy[2]}, 32'd0);
        rst_n = 1'b1;
        step();
        check("rel_ready_a", {31'd0, rdy[0]}, 32'd1);
        check("rel_ready_c", {31'd0, rdy[2]}, 32'd1);

        // Test 1: single word
        push(0, 32'h1111_1111, 1'b1);
        wait_dv(0, 2);
        check("t1_dout", dout[0], 32'h1111_1111);
        check("t1_level", lvl[0], 32'd1);
        rd_en[0] = 1'b1;
        step();
        rd_en[0] = 1'b0;
        check("t1_dv_after_pop", {31'd0, dv[0]}, 32'd0);
        check("t1_level_after_pop", lvl[0], 32'd0);

        // Test 2: burst of ten, back-to-back pops, then rd_en on empty
        for (int k = 0; k < 10; k++) push(0, k, 1'b1);
        repeat (3) step();
        check("t2_level", lvl[0], 32'd10);
        gaps = 0;
        rd_en[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (!dv[0]) gaps++;
            step();
        end
        check("t2_gaps", gaps, 32'd0);
        check("t2_dv_after_10", {31'd0, dv[0]}, 32'd0);
        repeat (3) step();
        rd_en[0] = 1'b0;
        check("t2_level_idle", lvl[0], 32'd0);
        check("t2_dv_idle", {31'd0, dv[0]}, 32'd0);
        check("t2_dout_hold", dout[0], 32'd9);

        // Test 3: backpressure at DEPTH=8
        for (int k = 0; k < 8; k++) push(1, k, 1'b1);
        wvalid[1] = 1'b1;
        wdata[1]  = 32'd8;
        repeat (3) step();
        check("t3_ready_full", {31'd0, rdy[1]}, 32'd0);
        check("t3_level_full", lvl[1], 32'd8);
        rd_en[1] = 1'b1;
        step();
        rd_en[1] = 1'b0;
        check("t3_ready_after_pop", {31'd0, rdy[1]}, 32'd1);
        check("t3_level_after_pop", lvl[1], 32'd7);
        step();
        sb_push(1, 32'd8);
        wvalid[1] = 1'b0;
        check("t3_level_refill", lvl[1], 32'd8);
        check("t3_ready_refull", {31'd0, rdy[1]}, 32'd0);
        rd_en[1] = 1'b1;
        for (int k = 9; k < 12; k++) push(1, k, 1'b1);
        drain(1, "t3_drain");

        // Test 5: pointer wrap at steady level 4
        for (int k = 0; k < 4; k++) push(1, 32'h100 + k, 1'b1);
        repeat (3) step();
        check("t5_level_start", lvl[1], 32'd4);
        gaps = 0;
        rd_en[1] = 1'b1;
        for (int k = 0; k < 50; k++) begin
            wvalid[1] = 1'b1;
            wdata[1]  = 32'h104 + k;
            if (!rdy[1] || !dv[1]) gaps++;
            sb_push(1, 32'h104 + k);
            step();
        end
        wvalid[1] = 1'b0;
        check("t5_gaps", gaps, 32'd0);
        check("t5_level_end", lvl[1], 32'd4);
        drain(1, "t5_drain");

        // Test 4: drop-when-full, clr_stats priority, drop on a pop cycle
        for (int k = 0; k < 11; k++) push(2, k, k < 8);
        check("t4_drop3", drops[2], 32'd3);
        check("t4_level", lvl[2], 32'd8);
        wvalid[2] = 1'b1;
        wdata[2]  = 32'hDEAD_0000;
        clr[2]    = 1'b1;
        step();
        clr[2] = 1'b0;
        check("t4_clr_vs_drop", drops[2], 32'd0);
        wdata[2] = 32'h77;
        rd_en[2] = 1'b1;
        step();
        wvalid[2] = 1'b0;
        check("t4_drop_on_pop", drops[2], 32'd1);
        check("t4_level_on_pop", lvl[2], 32'd7);
        drain(2, "t4_drain");

        // Test 6: reset mid-stream
        for (int k = 0; k < 5; k++) push(0, 32'hA0 + k, 1'b0);
        repeat (3) step();
        check("t6_level_pre", lvl[0], 32'd5);
        rst_n = 1'b0;
        step();
        check("t6_dv", {31'd0, dv[0]}, 32'd0);
        check("t6_level", lvl[0], 32'd0);
        check("t6_drop_c", drops[2], 32'd0);
        check("t6_dout", dout[0], 32'd0);
        rst_n = 1'b1;
        step();
        push(0, 32'hCAFE_BABE, 1'b1);
        wait_dv(0, 2);
        check("t6_first_word", dout[0], 32'hCAFE_BABE);
        rd_en[0] = 1'b1;
        step();
        rd_en[0] = 1'b0;
        check("t6_level_end", lvl[0], 32'd0);
        check("end_sb_a", sb_size(0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
